// File: rtl/disp_pkg.sv
// Shared constants and state encoding for the multiplexed display scanner.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package disp_pkg;

   localparam int NUM_DIG = 7;
   localparam int SEG_W   = 8;
   localparam int DIG_W   = 3;
   localparam int CNT_W   = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DEAD  = 2'd1,
      DRIVE = 2'd2
   } state_t;

endpackage

// File: rtl/scan_timer.sv
// Slot counter and digit index for the display scanner, with slot/frame wrap flags.
// Latency: cnt/dig update one cycle after run; wrap flags are combinational from cnt/dig.
// Backpressure: none; clr forces both counters to zero and holds them there.
module scan_timer
   import disp_pkg::*;
#(
   parameter int SCAN_DIV = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             run,
   output logic [CNT_W-1:0] cnt,
   output logic [DIG_W-1:0] dig,
   output logic             slot_end,
   output logic             frame_end
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIG - 1);

   assign slot_end  = (cnt == CNT_LAST);
   assign frame_end = slot_end && (dig == DIG_LAST);

   // Count cycles within a slot; step to the next digit at the end of each slot.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         cnt <= '0;
         dig <= '0;
      end else if (run) begin
         if (slot_end) begin
            cnt <= '0;
            dig <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/disp_scan.sv
// Seven-digit multiplexed LED scanner with blanking, PWM brightness and frame-locked shadow.
// Latency: an/seg registered one cycle after the state they reflect; frame_tick is registered.
// Backpressure: none; en=0 parks the scanner in IDLE with outputs dark on the next cycle.
module disp_scan
   import disp_pkg::state_t, disp_pkg::IDLE, disp_pkg::DRIVE,
          disp_pkg::NUM_DIG, disp_pkg::SEG_W, disp_pkg::CNT_W, disp_pkg::DIG_W;
#(
   parameter int SCAN_DIV    = 1000,
   parameter int DEAD        = 16,
   parameter bit AN_ACT_LOW  = 1'b1,
   parameter bit SEG_ACT_LOW = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_DIG*SEG_W-1:0] disp_reg,
   input  logic                     en,
   input  logic [3:0]               bright,
   output logic [SEG_W-1:0]         seg,
   output logic [NUM_DIG-1:0]       an,
   output logic                     frame_tick
);

   // The DEAD parameter hides the enum label of the same name, so the label is qualified.
   localparam state_t              SLOT_START = (DEAD == 0) ? DRIVE : disp_pkg::DEAD;
   localparam logic [CNT_W-1:0]    DEAD_LAST  = (DEAD == 0) ? '0 : CNT_W'(DEAD - 1);
   localparam logic [NUM_DIG-1:0]  AN_INV     = {NUM_DIG{AN_ACT_LOW}};
   localparam logic [SEG_W-1:0]    SEG_INV    = {SEG_W{SEG_ACT_LOW}};

   state_t                     state;
   logic [NUM_DIG*SEG_W-1:0]   shadow;
   logic [3:0]                 pwm_ph;
   logic [CNT_W-1:0]           cnt;
   logic [DIG_W-1:0]           dig;
   logic                       slot_end;
   logic                       frame_end;
   logic [NUM_DIG-1:0]         an_log;
   logic [SEG_W-1:0]           seg_log;

   scan_timer #(
      .SCAN_DIV (SCAN_DIV)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       ((state == IDLE) || !en),
      .run       (state != IDLE),
      .cnt       (cnt),
      .dig       (dig),
      .slot_end  (slot_end),
      .frame_end (frame_end)
   );

   // Logical drive: segments follow the shadow through the whole DRIVE phase, anode is PWM-gated.
   always_comb begin
      an_log  = '0;
      seg_log = '0;
      if (en && state == DRIVE) begin
         seg_log = shadow[dig*SEG_W +: SEG_W];
         if (pwm_ph < bright) begin
            an_log = NUM_DIG'(1) << dig;
         end
      end
   end

   // Scan state machine, shadow reloads, PWM phase and polarity-adjusted output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         shadow     <= '0;
         pwm_ph     <= '0;
         frame_tick <= 1'b0;
         an         <= AN_INV;
         seg        <= SEG_INV;
      end else begin
         pwm_ph     <= pwm_ph + 1'b1;
         frame_tick <= 1'b0;
         an         <= an_log ^ AN_INV;
         seg        <= seg_log ^ SEG_INV;
         if (!en) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  shadow     <= disp_reg;
                  frame_tick <= 1'b1;
                  state      <= SLOT_START;
               end
               default: begin
                  if (slot_end) begin
                     state <= SLOT_START;
                     if (frame_end) begin
                        shadow     <= disp_reg;
                        frame_tick <= 1'b1;
                     end
                  end else if (state == disp_pkg::DEAD && cnt == DEAD_LAST) begin
                     state <= DRIVE;
                  end
               end
            endcase
         end
      end
   end

endmodule
